data_receive: RTL
=================

# data_receive

UART receive-side counterpart of the multi-byte sender. It deserialises 8N1 frames from the `uartRx` line and assembles `BYTENUM` consecutive bytes into one `8*BYTENUM`-bit word. When the word is complete it updates `dataOut` and pulses `dataRxDone`. It sits at the serial-port boundary, after the pin, and feeds the parallel consumer; it uses the same `CLKFREQ`/`BAUDRATE` parameterisation as the transmit path so both ends agree on bit timing.

## Interface
- `CLKFREQ`, default 100_000_000: clock frequency in Hz.
- `BAUDRATE`, default 115200: line bit rate.
- `BYTENUM`, default 7: bytes per assembled word.
- `clk`  in  1: system clock. Everything is on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `enable`  in  1: receiver enable. While low, the receiver is held idle and any partial word is discarded.
- `uartRx`  in  1: serial input. Asynchronous to `clk`; the line idles high.
- `dataOut`  out  8*BYTENUM: last completed word. Holds its value until the next completed word.
- `dataRxDone`  out  1: one-cycle pulse when `dataOut` is updated.
- `frameError`  out  1: one-cycle pulse when a stop bit is sampled low.

## Operation
- **Bit period:** BAUDDIV = CLKFREQ/BAUDRATE, integer-truncated (868 at the defaults). HALFDIV = BAUDDIV/2.
- **Input synchroniser:** `uartRx` passes through 2 flops, both reset to 1. All logic uses the synchronised value `rxS`.
- **Byte format:** 8N1. Data bits arrive LSB first.
- **Word packing:**
  - The first received byte of a word goes to `dataOut[8*BYTENUM-1 -: 8]`, i.e. most-significant byte first.
  - Later bytes fill successively lower byte lanes.
- **FSM states:**
  - IDLE: a falling edge on `rxS` (previous 1, current 0) with `enable`=1 goes to START and clears the bit timer.
  - START: when the timer reaches HALFDIV-1, sample `rxS`.
    - If 0, go to DATA with bitIdx=0 and timer cleared.
    - If 1, treat it as a glitch and return to IDLE without touching the byte count.
  - DATA: each time the timer reaches BAUDDIV-1, shift `rxS` into the shift register at bit bitIdx. After bit 7, go to STOP.
  - STOP: when the timer reaches BAUDDIV-1, sample `rxS`.
    - If 1: write the byte into lane byteCnt.
      - If byteCnt = BYTENUM-1: register the full word into `dataOut`, pulse `dataRxDone`, clear byteCnt.
      - Otherwise increment byteCnt.
    - If 0: pulse `frameError`, clear byteCnt, discard the partial word, and go to IDLE. A new start is recognised only after `rxS` has been seen high.
- **Inter-byte timeout:**
  - A counter runs in IDLE while byteCnt ≠ 0.
  - If it reaches 20*BAUDDIV cycles (2 character times) with no start edge, byteCnt clears silently. There is no done or error pulse.
  - The counter clears on every start edge.
- **Enable:**
  - `enable`=0 forces IDLE, clears byteCnt and all timers, and ignores the line.
  - Deasserting `enable` mid-byte aborts that byte.
  - `dataOut` is unaffected by `enable`.
- **Simultaneous events:** the timeout expiring in the same cycle as a start edge is resolved in favour of the start edge; the count is then preserved.

## Timing
- **Reset values:** `dataOut`=0, `dataRxDone`=0, `frameError`=0, FSM=IDLE, byteCnt=0, all timers 0, synchroniser flops = 1.
- **Reset mid-operation:** all outputs clear immediately (asynchronously), with no wait for a clock edge. The partial word is lost.
- **Data sample points:** every data bit is sampled at 1.5 + k bit periods (k=0..7) after the start edge is detected, i.e. at mid-bit, with ±1 clk quantisation. The stop bit is sampled at 9.5 bit periods after the start edge.
- **Output update:** `dataOut` and `dataRxDone` update on the clock edge that follows the stop-bit sample of the last byte.
  - `dataRxDone` is high for exactly one cycle.
  - `dataOut` is valid in the same cycle as the pulse.
- **`frameError`:** high for exactly one cycle, on the clock edge that follows the failing stop sample.
- **Input latency:** 2 clk of synchroniser delay between the `uartRx` pin and the FSM.
- **Back-to-back bytes:** bytes with zero idle gap between the stop bit and the next start bit must be received without loss.

## Test plan
1. **Word reception:** BYTENUM=7, 100 MHz, 115200 baud. Drive the 7 bytes 00 00 00 00 00 4E 20 back-to-back -> `dataOut`=56'h0000000000_4E20, with exactly one `dataRxDone` pulse about 9.5 bit-times after the 7th start edge.
2. **Glitch rejection:** a low pulse of 100 clk on an idle line -> no byte is accepted, byteCnt stays 0, no pulses. A valid 7-byte word sent afterwards is received correctly.
3. **Framing error:** the 3rd byte is sent with its stop bit low -> one `frameError` pulse, no `dataRxDone`, `dataOut` keeps its previous value. A following clean 7-byte word (incrementing by 20000, e.g. 0x9C40) yields `dataOut`=56'h9C40.
4. **Inter-byte timeout:** send 3 bytes, idle for 25 bit-times, then send 7 bytes AA..A0 -> exactly one `dataRxDone`, and `dataOut` contains only the later 7 bytes.
5. **Asynchronous reset mid-byte:** assert `reset` for 300 ns in the middle of byte 4 -> `dataOut`, `dataRxDone` and `frameError` read 0 before the next clk edge. The next full word is received correctly.
6. **Enable gating:** hold `enable`=0 while a full word is sent -> no pulses, `dataOut` unchanged. Drop `enable` during byte 5 of a word -> that word is discarded, and the next word received with `enable`=1 is correct.

Source files
------------

// File: rtl/data_receive.sv
// -----------------------------------------------------------------------------
// data_receive
//
// UART (8N1) receiver that assembles BYTENUM consecutive bytes into one
// 8*BYTENUM-bit word. The first byte of a word lands in the most-significant
// byte lane, and later bytes fill successively lower lanes. When the last byte
// of a word passes its stop-bit check, the word is registered onto dataOut and
// dataRxDone pulses for one cycle. A low stop bit pulses frameError and drops
// the partial word. A silence of 2 character times between bytes also drops the
// partial word, without any pulse.
//
// Parameters
//   CLKFREQ   clock frequency in Hz
//   BAUDRATE  line bit rate; bit period = CLKFREQ/BAUDRATE clocks (truncated)
//   BYTENUM   bytes per assembled word
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   enable      receiver enable; low holds the receiver idle and drops any
//               partial word (dataOut is left untouched)
//   uartRx      serial input, asynchronous to clk, idles high
//   dataOut     last completed word, held until the next one completes
//   dataRxDone  one-cycle pulse when dataOut is updated
//   frameError  one-cycle pulse when a stop bit is sampled low
// -----------------------------------------------------------------------------
module data_receive #(
  parameter int CLKFREQ  = 100_000_000,
  parameter int BAUDRATE = 115200,
  parameter int BYTENUM  = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   uartRx,
  output logic [8*BYTENUM-1:0]   dataOut,
  output logic                   dataRxDone,
  output logic                   frameError
);

  localparam int BAUDDIV = CLKFREQ / BAUDRATE;
  localparam int HALFDIV = BAUDDIV / 2;
  localparam int TOUTDIV = 20 * BAUDDIV;
  localparam int WORD_W  = 8 * BYTENUM;
  localparam int TMR_W   = $clog2(BAUDDIV);
  localparam int TO_W    = $clog2(TOUTDIV);
  localparam int CNT_W   = (BYTENUM > 1) ? $clog2(BYTENUM) : 1;

  localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(BAUDDIV - 1);
  localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(HALFDIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TOUTDIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BYTENUM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Input synchroniser and edge-detect history
  logic rx_meta_q;
  logic rx_sync_q;
  logic rx_prev_q;

  // FSM and timing control
  state_t             state_q,    state_d;
  logic [TMR_W-1:0]   timer_q,    timer_d;
  logic [2:0]         bit_idx_q,  bit_idx_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]    tout_q,     tout_d;

  // Datapath
  logic [7:0]         shift_q,    shift_d;
  logic [WORD_W-1:0]  word_q,     word_d;
  logic [WORD_W-1:0]  word_ins;

  // Outputs
  logic [WORD_W-1:0]  data_out_q, data_out_d;
  logic               done_q,     done_d;
  logic               ferr_q,     ferr_d;

  logic rx_s;
  logic start_edge;

  assign rx_s = rx_sync_q;

  // A start edge needs the line to have been seen high first, which also
  // blocks re-triggering after a frame error until the line recovers.
  assign start_edge = enable & rx_prev_q & ~rx_s;

  // Current word with the just-completed byte dropped into lane byte_cnt_q.
  always_comb begin
    word_ins = word_q;
    for (int l = 0; l < BYTENUM; l++) begin
      if (CNT_W'(l) == byte_cnt_q) begin
        word_ins[8*(BYTENUM-1-l) +: 8] = shift_q;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    tout_d     = tout_q;
    shift_d    = shift_q;
    word_d     = word_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;

    if (!enable) begin
      state_d    = S_IDLE;
      timer_d    = '0;
      bit_idx_d  = '0;
      byte_cnt_d = '0;
      tout_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A start edge wins over a timeout expiring in the same cycle.
          if (start_edge) begin
            state_d = S_START;
            timer_d = '0;
            tout_d  = '0;
          end else if (byte_cnt_q != '0) begin
            if (tout_q == TO_LAST) begin
              byte_cnt_d = '0;
              tout_d     = '0;
            end else begin
              tout_d = tout_q + TO_W'(1);
            end
          end else begin
            tout_d = '0;
          end
        end

        S_START: begin
          if (timer_q == HALF_LAST) begin
            timer_d = '0;
            if (!rx_s) begin
              state_d   = S_DATA;
              bit_idx_d = '0;
            end else begin
              // Line back high at mid start bit: a glitch, not a frame.
              state_d = S_IDLE;
            end
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end

        S_DATA: begin
          if (timer_q == BIT_LAST) begin
            timer_d            = '0;
            shift_d[bit_idx_q] = rx_s;
            if (bit_idx_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end

        S_STOP: begin
          if (timer_q == BIT_LAST) begin
            timer_d = '0;
            state_d = S_IDLE;
            if (rx_s) begin
              word_d = word_ins;
              if (byte_cnt_q == CNT_LAST) begin
                data_out_d = word_ins;
                done_d     = 1'b1;
                byte_cnt_d = '0;
              end else begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
              end
            end else begin
              ferr_d     = 1'b1;
              byte_cnt_d = '0;
            end
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Control, synchroniser and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      byte_cnt_q <= '0;
      tout_q     <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= uartRx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      byte_cnt_q <= byte_cnt_d;
      tout_q     <= tout_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  // Byte and word assembly registers; every lane is rewritten before use,
  // so they need no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    word_q  <= word_d;
  end

  assign dataOut    = data_out_q;
  assign dataRxDone = done_q;
  assign frameError = ferr_q;

endmodule
